// File: rtl/layer_pkg.sv
// Shared defaults and helpers for the layer compositor: default geometry,
// transparent key, rank type and the triangular pair-index mapping.
package layer_pkg;

    localparam int          DEF_NUM_LAYERS = 4;
    localparam int          DEF_CW         = 4;
    localparam logic [11:0] DEF_TKEY       = 12'h000;

    // Wide enough for the largest supported layer count (16).
    localparam int RANK_W = 4;
    typedef logic [RANK_W-1:0] rank_t;

    // Bit position of pair (i<j) in an i-major packing of n layers.
    function automatic int pair_idx(input int i, input int j, input int n);
        return (i * (2 * n - i - 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/layer_compositor_prio_select.sv
// Combinational argmin over the ranks of qualified layers; ties go to the
// lowest layer index because only a strictly smaller rank displaces the winner.
module prio_select
    import layer_pkg::*;
#(
    parameter  int N  = DEF_NUM_LAYERS,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        qual,
    input  logic [N*RANK_W-1:0] ranks,
    output logic [IW-1:0]       win_idx,
    output logic                any_hit
);

    rank_t best_s;
    rank_t cur_s;
    logic  take_s;

    // Linear scan keeping the best qualified rank seen so far.
    always_comb begin
        win_idx = {IW{1'b0}};
        any_hit = 1'b0;
        best_s  = {RANK_W{1'b1}};
        cur_s   = {RANK_W{1'b0}};
        take_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur_s   = ranks[i*RANK_W +: RANK_W];
            take_s  = qual[i] & (~any_hit | (cur_s < best_s));
            best_s  = take_s ? cur_s : best_s;
            win_idx = take_s ? IW'(i) : win_idx;
            any_hit = any_hit | take_s;
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor: stage 1 qualifies layers against the colour key,
// stage 2 picks the highest-priority layer, and a per-frame collision map is kept.
module layer_compositor
    import layer_pkg::*;
#(
    parameter int                NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int                CW         = DEF_CW,
    parameter logic [3*CW-1:0]   TKEY       = DEF_TKEY,
    localparam int               RGB_W      = 3 * CW,
    localparam int               IW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int               NP         = NUM_LAYERS * (NUM_LAYERS - 1) / 2
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        pix_valid,
    input  logic                        startOfFrame,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]       layer_draw,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic                        prio_we,
    input  logic [IW-1:0]               prio_idx,
    input  logic [IW-1:0]               prio_rank,
    output logic [CW-1:0]               Red_level,
    output logic [CW-1:0]               Green_level,
    output logic [CW-1:0]               Blue_level,
    output logic                        out_valid,
    output logic [NP-1:0]               collision,
    output logic                        frame_done
);

    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_sof_q, s1_sof_d;
    logic [NUM_LAYERS-1:0]        s1_qual_q, s1_qual_d;
    logic [NUM_LAYERS*RGB_W-1:0]  s1_rgb_q, s1_rgb_d;
    logic [RGB_W-1:0]             s1_bg_q, s1_bg_d;
    logic [NUM_LAYERS*RANK_W-1:0] s1_rank_q, s1_rank_d;
    logic [NUM_LAYERS*RANK_W-1:0] rank_q, rank_d;
    logic                         out_valid_q, out_valid_d;
    logic [RGB_W-1:0]             rgb_q, rgb_d;
    logic [NP-1:0]                acc_q, acc_d;
    logic [NP-1:0]                coll_q, coll_d;
    logic                         fd_q, fd_d;
    logic                         in_frame_q, in_frame_d;
    logic [NP-1:0]                pairs_s;
    logic [IW-1:0]                win_idx_s;
    logic                         any_hit_s;

    // Stage-1 capture; ranks are snapshotted so a pixel keeps the table it was issued with.
    always_comb begin
        s1_valid_d = pix_valid;
        s1_sof_d   = pix_valid & startOfFrame;
        s1_rgb_d   = layer_rgb;
        s1_bg_d    = bg_rgb;
        s1_rank_d  = rank_q;
        s1_qual_d  = {NUM_LAYERS{1'b0}};
        for (int i = 0; i < NUM_LAYERS; i++) begin
            s1_qual_d[i] = pix_valid & layer_draw[i] &
                           (layer_rgb[i*RGB_W +: RGB_W] != TKEY);
        end
    end

    // Priority-table write port; out-of-range indices are dropped.
    always_comb begin
        rank_d = rank_q;
        if (prio_we && (int'(prio_idx) < NUM_LAYERS)) begin
            rank_d[prio_idx*RANK_W +: RANK_W] = rank_t'(prio_rank);
        end else begin
            rank_d = rank_q;
        end
    end

    prio_select #(
        .N (NUM_LAYERS)
    ) u_prio_select (
        .qual    (s1_qual_q),
        .ranks   (s1_rank_q),
        .win_idx (win_idx_s),
        .any_hit (any_hit_s)
    );

    // Stage-2 colour selection; colour holds across invalid pixels.
    always_comb begin
        out_valid_d = s1_valid_q;
        if (s1_valid_q) begin
            if (any_hit_s) begin
                rgb_d = s1_rgb_q[win_idx_s*RGB_W +: RGB_W];
            end else begin
                rgb_d = s1_bg_q;
            end
        end else begin
            rgb_d = rgb_q;
        end
    end

    // Collision accumulation; nothing accumulates until the first frame start after reset.
    always_comb begin
        pairs_s = {NP{1'b0}};
        for (int i = 0; i < NUM_LAYERS; i++) begin
            for (int j = i + 1; j < NUM_LAYERS; j++) begin
                pairs_s[pair_idx(i, j, NUM_LAYERS)] = s1_qual_q[i] & s1_qual_q[j];
            end
        end
        acc_d      = acc_q;
        coll_d     = coll_q;
        fd_d       = 1'b0;
        in_frame_d = in_frame_q;
        if (s1_valid_q && s1_sof_q) begin
            coll_d     = acc_q;
            acc_d      = pairs_s;
            fd_d       = 1'b1;
            in_frame_d = 1'b1;
        end else if (s1_valid_q && in_frame_q) begin
            acc_d = acc_q | pairs_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_valid_q  <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_qual_q   <= {NUM_LAYERS{1'b0}};
            s1_rgb_q    <= {(NUM_LAYERS*RGB_W){1'b0}};
            s1_bg_q     <= {RGB_W{1'b0}};
            s1_rank_q   <= {(NUM_LAYERS*RANK_W){1'b0}};
            for (int i = 0; i < NUM_LAYERS; i++) begin
                rank_q[i*RANK_W +: RANK_W] <= rank_t'(i);
            end
            out_valid_q <= 1'b0;
            rgb_q       <= {RGB_W{1'b1}};
            acc_q       <= {NP{1'b0}};
            coll_q      <= {NP{1'b0}};
            fd_q        <= 1'b0;
            in_frame_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sof_q    <= s1_sof_d;
            s1_qual_q   <= s1_qual_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_bg_q     <= s1_bg_d;
            s1_rank_q   <= s1_rank_d;
            rank_q      <= rank_d;
            out_valid_q <= out_valid_d;
            rgb_q       <= rgb_d;
            acc_q       <= acc_d;
            coll_q      <= coll_d;
            fd_q        <= fd_d;
            in_frame_q  <= in_frame_d;
        end
    end

    assign Red_level   = rgb_q[RGB_W-1 -: CW];
    assign Green_level = rgb_q[2*CW-1 -: CW];
    assign Blue_level  = rgb_q[CW-1 -: CW];
    assign out_valid   = out_valid_q;
    assign collision   = coll_q;
    assign frame_done  = fd_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: a cycle-level reference model of the
// compositing and collision rules checked every cycle, plus literal spot checks.
module tb_layer_compositor;

    localparam int N     = 4;
    localparam int CW    = 4;
    localparam int RGB_W = 12;
    localparam int NP    = 6;

    logic             clk = 1'b0;
    logic             resetN = 1'b1;
    logic             pix_valid = 1'b0;
    logic             startOfFrame = 1'b0;
    logic [N*RGB_W-1:0] layer_rgb = '0;
    logic [N-1:0]     layer_draw = '0;
    logic [RGB_W-1:0] bg_rgb = '0;
    logic             prio_we = 1'b0;
    logic [1:0]       prio_idx = '0;
    logic [1:0]       prio_rank = '0;
    logic [CW-1:0]    red_s, green_s, blue_s;
    logic             out_valid;
    logic [NP-1:0]    collision;
    logic             frame_done;

    layer_compositor #(.NUM_LAYERS(N), .CW(CW), .TKEY(12'h000)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .pix_valid    (pix_valid),
        .startOfFrame (startOfFrame),
        .layer_rgb    (layer_rgb),
        .layer_draw   (layer_draw),
        .bg_rgb       (bg_rgb),
        .prio_we      (prio_we),
        .prio_idx     (prio_idx),
        .prio_rank    (prio_rank),
        .Red_level    (red_s),
        .Green_level  (green_s),
        .Blue_level   (blue_s),
        .out_valid    (out_valid),
        .collision    (collision),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int            m_rank [N];
    logic          m_d1_v, m_d1_sof;
    logic [11:0]   m_d1_rgb;
    logic [NP-1:0] m_d1_pairs;
    logic          m_out_v;
    logic [11:0]   m_out_rgb;
    logic [NP-1:0] m_coll, m_acc;
    logic          m_fd, m_in_frame;
    logic          chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_out_v});
            chk("rgb", {20'd0, red_s, green_s, blue_s}, {20'd0, m_out_rgb});
            chk("collision", {26'd0, collision}, {26'd0, m_coll});
            chk("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
        end
    end

    function automatic logic [N*RGB_W-1:0] lay(input logic [11:0] c0, input logic [11:0] c1,
                                               input logic [11:0] c2, input logic [11:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    // Visible colour: search ranks from most to least important, lowest index first.
    function automatic logic [11:0] ref_pix(input logic [N-1:0] q, input logic [N*RGB_W-1:0] rgbs,
                                            input logic [11:0] bg);
        for (int r = 0; r < N; r++)
            for (int i = 0; i < N; i++)
                if (q[i] && m_rank[i] == r) return rgbs[i*RGB_W +: RGB_W];
        return bg;
    endfunction

    function automatic logic [NP-1:0] ref_pairs(input logic [N-1:0] q);
        logic [NP-1:0] p = '0;
        int k = 0;
        for (int i = 0; i < N; i++)
            for (int j = i + 1; j < N; j++) begin
                p[k] = q[i] & q[j];
                k++;
            end
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_rank[i] = i;
        m_d1_v = 1'b0; m_d1_sof = 1'b0; m_d1_rgb = '0; m_d1_pairs = '0;
        m_out_v = 1'b0; m_out_rgb = 12'hFFF;
        m_coll = '0; m_acc = '0; m_fd = 1'b0; m_in_frame = 1'b0;
    endtask

    task automatic step(input logic v, input logic sof, input logic [N-1:0] draw,
                        input logic [N*RGB_W-1:0] rgbs, input logic [11:0] bg,
                        input logic we, input logic [1:0] idx, input logic [1:0] rk);
        logic [N-1:0]  q;
        logic [11:0]   e_rgb;
        logic [NP-1:0] e_pairs;
        pix_valid = v; startOfFrame = sof; layer_draw = draw; layer_rgb = rgbs;
        bg_rgb = bg; prio_we = we; prio_idx = idx; prio_rank = rk;
        for (int i = 0; i < N; i++)
            q[i] = v & draw[i] & (rgbs[i*RGB_W +: RGB_W] != 12'h000);
        e_rgb   = ref_pix(q, rgbs, bg);
        e_pairs = ref_pairs(q);
        @(posedge clk);
        #1;
        m_out_v = m_d1_v;
        if (m_d1_v) m_out_rgb = m_d1_rgb;
        m_fd = 1'b0;
        if (m_d1_v && m_d1_sof) begin
            m_coll = m_acc; m_acc = m_d1_pairs; m_fd = 1'b1; m_in_frame = 1'b1;
        end else if (m_d1_v && m_in_frame) begin
            m_acc = m_acc | m_d1_pairs;
        end
        m_d1_v = v; m_d1_sof = v & sof; m_d1_rgb = e_rgb; m_d1_pairs = e_pairs;
        if (we && int'(idx) < N) m_rank[idx] = int'(rk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'b0000, '0, 12'h000, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic set_rank(input logic [1:0] idx, input logic [1:0] rk);
        step(1'b0, 1'b0, 4'b0000, '0, 12'h000, 1'b1, idx, rk);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        pix_valid = 1'b0; startOfFrame = 1'b0; prio_we = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rgb", {20'd0, red_s, green_s, blue_s}, 32'hFFF);
        chk("rst_collision", {26'd0, collision}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        logic [N*RGB_W-1:0] px;
        #2;
        do_reset();
        chk_en = 1'b1;
        step(1'b1, 1'b1, 4'b0000, '0, 12'h000, 1'b0, 2'd0, 2'd0);

        // Identity ranks: layer 0 beats layer 2
        px = lay(12'hF00, 12'h000, 12'h0F0, 12'h000);
        step(1'b1, 1'b0, 4'b0101, px, 12'h000, 1'b0, 2'd0, 2'd0);
        idle(1);
        chk("req030_rgb", {20'd0, red_s, green_s, blue_s}, 32'hF00);
        chk("req030_valid", {31'd0, out_valid}, 32'd1);

        // Rank writes affect only later pixels
        step(1'b1, 1'b0, 4'b0101, px, 12'h000, 1'b1, 2'd2, 2'd0);
        step(1'b1, 1'b0, 4'b0101, px, 12'h000, 1'b1, 2'd0, 2'd1);
        chk("req031_write_cycle", {20'd0, red_s, green_s, blue_s}, 32'hF00);
        step(1'b1, 1'b0, 4'b0101, px, 12'h000, 1'b0, 2'd0, 2'd0);
        chk("req031_tie_pixel", {20'd0, red_s, green_s, blue_s}, 32'hF00);
        idle(1);
        chk("req031_new_rank", {20'd0, red_s, green_s, blue_s}, 32'h0F0);
        set_rank(2'd0, 2'd0);
        set_rank(2'd2, 2'd2);

        // Equal ranks on layers 1 and 2
        set_rank(2'd2, 2'd1);
        step(1'b1, 1'b0, 4'b0110, lay(12'h000, 12'h0A0, 12'hA00, 12'h000), 12'h000, 1'b0, 2'd0, 2'd0);
        idle(1);
        chk("req034_tie", {20'd0, red_s, green_s, blue_s}, 32'h0A0);
        set_rank(2'd2, 2'd2);

        // Frame with transparent draws and one 1/3 overlap
        step(1'b1, 1'b1, 4'b0000, '0, 12'h000, 1'b0, 2'd0, 2'd0);
        step(1'b1, 1'b0, 4'b0010, lay(12'h000, 12'h000, 12'h000, 12'h000), 12'h00F, 1'b0, 2'd0, 2'd0);
        idle(1);
        chk("req032_bg", {20'd0, red_s, green_s, blue_s}, 32'h00F);
        step(1'b1, 1'b0, 4'b0110, lay(12'h000, 12'h000, 12'h222, 12'h000), 12'h00F, 1'b0, 2'd0, 2'd0);
        step(1'b1, 1'b0, 4'b1010, lay(12'h000, 12'h111, 12'h000, 12'h333), 12'h00F, 1'b0, 2'd0, 2'd0);
        step(1'b0, 1'b1, 4'b0000, '0, 12'h000, 1'b0, 2'd0, 2'd0);
        idle(1);
        chk("req033_overlap_rgb", {20'd0, red_s, green_s, blue_s}, 32'h111);
        step(1'b1, 1'b1, 4'b0000, '0, 12'h000, 1'b0, 2'd0, 2'd0);
        idle(1);
        chk("req033_frame_done", {31'd0, frame_done}, 32'd1);
        chk("req033_pair13", {26'd0, collision}, 32'h10);
        step(1'b1, 1'b0, 4'b0001, lay(12'h777, 12'h000, 12'h000, 12'h000), 12'h000, 1'b0, 2'd0, 2'd0);
        step(1'b1, 1'b1, 4'b0000, '0, 12'h000, 1'b0, 2'd0, 2'd0);
        idle(1);
        chk("req033_clean", {26'd0, collision}, 32'h0);

        // Reset with colliding pixels in flight
        px = lay(12'h123, 12'h456, 12'h000, 12'h000);
        step(1'b1, 1'b0, 4'b0011, px, 12'h000, 1'b0, 2'd0, 2'd0);
        step(1'b1, 1'b0, 4'b0011, px, 12'h000, 1'b0, 2'd0, 2'd0);
        do_reset();
        step(1'b1, 1'b1, 4'b0000, '0, 12'h000, 1'b0, 2'd0, 2'd0);
        idle(1);
        chk("req035_first_coll", {26'd0, collision}, 32'h0);
        step(1'b1, 1'b0, 4'b0011, px, 12'h000, 1'b0, 2'd0, 2'd0);
        step(1'b1, 1'b1, 4'b0000, '0, 12'h000, 1'b0, 2'd0, 2'd0);
        idle(1);
        chk("req035_pair01", {26'd0, collision}, 32'h1);
        idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
